// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants, types and helpers for the two-layer feed-forward network
// sequencer (4 inputs -> 6 hidden -> 2 outputs).
//   - Geometry: weight width, fan-ins, neuron counts, layer-2 base address
//   - Datapath widths: operand, product, accumulator, RAM word/address
//   - state_e / layer_e: sequencer state and active-layer flag
//   - relu_sat(): hidden-neuron activation (ReLU, >>>7 scale, 8-bit clamp)
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int unsigned WWIDTH   = 8;
    localparam int unsigned XWIDTH   = 8;
    localparam int unsigned N_IN     = 4;
    localparam int unsigned N_HID    = 6;
    localparam int unsigned N_OUT    = 2;
    localparam int unsigned L2_BASE  = 8;
    localparam int unsigned PROD_W   = XWIDTH + WWIDTH + 1;
    localparam int unsigned ACC_W    = 21;
    localparam int unsigned RAM_W    = 256;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SCALE_SH = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MAC,
        ST_STORE,
        ST_DONE
    } state_e;

    typedef enum logic {
        LAYER_L1,
        LAYER_L2
    } layer_e;

    // Non-positive sums clamp to 0; otherwise scale down and clamp to 255.
    function automatic logic [XWIDTH-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] scaled;
        scaled = acc >>> SCALE_SH;
        if (acc[ACC_W-1] || (acc == '0)) begin
            return '0;
        end else if (|scaled[ACC_W-1:XWIDTH]) begin
            return '1;
        end else begin
            return scaled[XWIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// -----------------------------------------------------------------------------
// nn_mac_unit
// Serial multiply-accumulate: unsigned 8-bit operand times signed 8-bit weight,
// added into a 21-bit signed accumulator.
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset (clears accumulator)
//   operand_i  in   unsigned operand (input x or hidden activation h)
//   weight_i   in   signed weight slice from the RAM word
//   acc_en_i   in   add the product this cycle
//   acc_clr_i  in   clear the accumulator (has priority over acc_en_i)
//   acc_o      out  accumulator value
// -----------------------------------------------------------------------------
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [XWIDTH-1:0]        operand_i,
    input  logic signed [WWIDTH-1:0] weight_i,
    input  logic                     acc_en_i,
    input  logic                     acc_clr_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [PROD_W-1:0] op_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Operand is zero-extended, weight sign-extended, so the 17-bit signed
    // product is exact.
    assign op_ext = $signed({{(PROD_W-XWIDTH){1'b0}}, operand_i});
    assign w_ext  = $signed({{(PROD_W-WWIDTH){weight_i[WWIDTH-1]}}, weight_i});
    assign prod   = op_ext * w_ext;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
// Walks the weight RAM one neuron word at a time and drives a serial MAC to
// evaluate layer 1 (4->6, ReLU/scale/saturate) then layer 2 (6->2, sign test).
//   CLK        in   clock
//   RST        in   synchronous active-high reset
//   start      in   request, sampled only in IDLE
//   x0..x3     in   unsigned inputs, captured when start is accepted
//   mem_rdata  in   RAM word, valid one cycle after mem_addr
//   mem_addr   out  RAM word address, held for a whole neuron
//   mem_we     out  RAM write enable (always 0)
//   busy       out  high while a request is in progress (incl. DONE)
//   done       out  one-cycle pulse, y0/y1 valid
//   y0, y1     out  output neuron decisions, held until the next done
// -----------------------------------------------------------------------------
module nn_layer_sequencer
    import nn_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        x0,
    input  logic [7:0]        x1,
    input  logic [7:0]        x2,
    input  logic [7:0]        x3,
    input  logic [RAM_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              y0,
    output logic              y1
);

    state_e                  state_q, state_d;
    layer_e                  layer_q;
    logic [IDX_W-1:0]        n_q;
    logic [IDX_W-1:0]        k_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [XWIDTH-1:0]       x_q [N_IN];
    logic [XWIDTH-1:0]       h_q [N_HID];
    logic [N_OUT-1:0]        yt_q;
    logic [N_OUT-1:0]        yt_d;
    logic [N_OUT-1:0]        y_q;

    logic [XWIDTH-1:0]       operand;
    logic signed [WWIDTH-1:0] weight;
    logic                    acc_en;
    logic                    acc_clr;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_pos;
    logic                    k_last;
    logic                    l1_last;
    logic                    l2_last;
    logic                    unused_rdata;

    assign k_last  = (layer_q == LAYER_L1) ? (k_q == IDX_W'(N_IN - 1))
                                           : (k_q == IDX_W'(N_HID - 1));
    assign l1_last = (n_q == IDX_W'(N_HID - 1));
    assign l2_last = (n_q == IDX_W'(N_OUT - 1));
    assign acc_pos = !acc[ACC_W-1] && (acc != '0);
    assign unused_rdata = ^mem_rdata[RAM_W-1:N_HID*WWIDTH];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_MAC;
            ST_MAC:   if (k_last) state_d = ST_STORE;
            ST_STORE: state_d = (layer_q == LAYER_L2 && l2_last) ? ST_DONE : ST_WAIT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        acc_en  = (state_q == ST_MAC);
        acc_clr = (state_q == ST_STORE) || (state_q == ST_IDLE && start);
    end

    // Operand / weight-slice selection by MAC index k
    always_comb begin
        operand = '0;
        weight  = '0;
        for (int unsigned i = 0; i < N_HID; i++) begin
            if (k_q == IDX_W'(i)) begin
                weight = $signed(mem_rdata[i*WWIDTH +: WWIDTH]);
            end
        end
        if (layer_q == LAYER_L1) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (k_q == IDX_W'(i)) operand = x_q[i];
            end
        end else begin
            for (int unsigned i = 0; i < N_HID; i++) begin
                if (k_q == IDX_W'(i)) operand = h_q[i];
            end
        end
    end

    always_comb begin
        yt_d = yt_q;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (n_q == IDX_W'(i)) yt_d[i] = acc_pos;
        end
    end

    // Datapath registers. The outputs load from yt_d as the last layer-2
    // neuron is stored, so y0/y1 change on the same edge that raises done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            layer_q <= LAYER_L1;
            n_q     <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            yt_q    <= '0;
            y_q     <= '0;
            for (int unsigned i = 0; i < N_IN; i++)  x_q[i] <= '0;
            for (int unsigned i = 0; i < N_HID; i++) h_q[i] <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q[0]  <= x0;
                        x_q[1]  <= x1;
                        x_q[2]  <= x2;
                        x_q[3]  <= x3;
                        addr_q  <= '0;
                        layer_q <= LAYER_L1;
                        n_q     <= '0;
                    end
                end
                ST_WAIT: k_q <= '0;
                ST_MAC:  k_q <= k_q + IDX_W'(1);
                ST_STORE: begin
                    if (layer_q == LAYER_L1) begin
                        for (int unsigned i = 0; i < N_HID; i++) begin
                            if (n_q == IDX_W'(i)) h_q[i] <= relu_sat(acc);
                        end
                        if (l1_last) begin
                            layer_q <= LAYER_L2;
                            n_q     <= '0;
                            addr_q  <= ADDR_W'(L2_BASE);
                        end else begin
                            n_q    <= n_q + IDX_W'(1);
                            addr_q <= {1'b0, n_q} + ADDR_W'(1);
                        end
                    end else begin
                        yt_q <= yt_d;
                        if (l2_last) begin
                            y_q <= yt_d;
                        end else begin
                            n_q    <= n_q + IDX_W'(1);
                            addr_q <= ADDR_W'(L2_BASE) + {1'b0, n_q} + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

    nn_mac_unit u_mac (
        .clk_i     (CLK),
        .rst_i     (RST),
        .operand_i (operand),
        .weight_i  (weight),
        .acc_en_i  (acc_en),
        .acc_clr_i (acc_clr),
        .acc_o     (acc)
    );

    assign mem_addr = addr_q;
    assign mem_we   = 1'b0;
    assign y0       = y_q[0];
    assign y1       = y_q[1];

endmodule
